instr_fetch_unit: RTL

// - Opcode producer for the MIPS control decoder: holds the PC, fetches 32-bit words from instruction memory via
//   req/ready handshake, presents the instruction and its opcode[5:0] to decode with valid/ready.
// - Consumes decoder Branch plus a bne qualifier and ALU zero to redirect the PC (beq/bne), closing the fetch->decode->fetch loop.

---
 rtl/mips_pkg.sv | 18 +
 rtl/branch_target_calc.sv | 25 ++
 rtl/instr_fetch_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: fetch FSM state encoding and the opcodes the
// control decoder and fetch unit agree on.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational beq/bne resolution: decides whether the branch is taken and
// forms the word-aligned target from pc4 plus the shifted, sign-extended immediate.
module branch_target_calc #(
    parameter int AW = 32
) (
    input  logic          br_valid,
    input  logic          br_en,
    input  logic          br_ne,
    input  logic          alu_zero,
    input  logic [15:0]   br_imm,
    input  logic [AW-1:0] br_pc4,
    output logic          taken,
    output logic [AW-1:0] target
);

    logic [AW-1:0] offset;
    logic [AW-1:0] sum;

    assign taken  = br_valid & br_en & (alu_zero ^ br_ne);
    assign offset = {{(AW-18){br_imm[15]}}, br_imm, 2'b00};
    assign sum    = br_pc4 + offset;
    // A misaligned br_pc4 would leak into the low bits; the PC is always word aligned.
    assign target = {sum[AW-1:2], 2'b00};

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, fetches words over a req/ready memory port and
// hands instructions to decode over valid/ready, redirecting on taken branches.
//
//   state    | meaning
//   ---------+------------------------------------------------------------------
//   ST_FETCH | request outstanding at fetch_addr (imem_req low only right after reset)
//   ST_DRAIN | redirect pending; wait out the old request, discard its data
//   ST_HOLD  | instruction presented to decode, waiting for instr_ready
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ready,
    input  logic [31:0]   imem_rdata,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [31:0]   instr,
    output logic [5:0]    opcode,
    output logic [AW-1:0] pc4,
    input  logic          br_valid,
    input  logic          br_en,
    input  logic          br_ne,
    input  logic          alu_zero,
    input  logic [15:0]   br_imm,
    input  logic [AW-1:0] br_pc4
);

    localparam logic [AW-1:0] PC_STEP    = AW'(4);
    localparam logic [AW-1:0] PC_INIT    = {RESET_PC[AW-1:2], 2'b00};

    fetch_state_t  state;
    logic [AW-1:0] pc;
    logic [AW-1:0] fetch_addr;
    logic          taken;
    logic [AW-1:0] target;

    branch_target_calc #(.AW(AW)) u_btc (
        .br_valid (br_valid),
        .br_en    (br_en),
        .br_ne    (br_ne),
        .alu_zero (alu_zero),
        .br_imm   (br_imm),
        .br_pc4   (br_pc4),
        .taken    (taken),
        .target   (target)
    );

    assign imem_addr = fetch_addr;
    assign opcode    = instr[31:26];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_FETCH;
            pc          <= PC_INIT;
            fetch_addr  <= PC_INIT;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            pc4         <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (!imem_req) begin
                        // First request after reset; a stray imem_ready here is ignored.
                        imem_req   <= 1'b1;
                        fetch_addr <= taken ? target : pc;
                        if (taken) pc <= target;
                    end else if (taken) begin
                        pc <= target;
                        if (imem_ready) fetch_addr <= target;
                        else            state      <= ST_DRAIN;
                    end else if (imem_ready) begin
                        instr       <= imem_rdata;
                        pc4         <= pc + PC_STEP;
                        pc          <= pc + PC_STEP;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= ST_HOLD;
                    end
                end
                ST_DRAIN: begin
                    // Address stays on the old request; the latest redirect wins.
                    if (taken) pc <= target;
                    if (imem_ready) begin
                        fetch_addr <= taken ? target : pc;
                        state      <= ST_FETCH;
                    end
                end
                ST_HOLD: begin
                    if (taken) begin
                        pc          <= target;
                        fetch_addr  <= target;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= ST_FETCH;
                    end else if (instr_ready) begin
                        fetch_addr  <= pc;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= ST_FETCH;
                    end
                end
                default: begin
                    state       <= ST_FETCH;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
